// File: rtl/pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_ctrl
// Purpose  : PLL reset/lock supervisor; releases sys_rst_n after stable lock,
//            retries the PLL on timeout or lock loss, latches lock_fail.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 24,
  localparam int RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             soft_req,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             lock_fail,
  output logic [RET_W-1:0] retries,
  output logic [7:0]       loss_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_rst_last     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
  localparam logic [RET_W-1:0] c_max_retries  = RET_W'(MAX_RETRIES);
  localparam logic [RET_W-1:0] c_ret_one      = RET_W'(1);

  logic             r_sync1, r_sync2;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [RET_W-1:0] r_retries, w_retries_nxt;
  logic [7:0]       r_loss, w_loss_nxt;
  logic             r_pll_rst, r_sys_rst_n, r_lock_fail;
  logic             w_locked_s;

  assign w_locked_s = r_sync2;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_retries_nxt = r_retries;
    w_loss_nxt    = r_loss;
    if (soft_req) begin
      // restart request wins over every other transition
      w_state_nxt   = ST_PLL_RESET;
      w_cnt_nxt     = '0;
      w_retries_nxt = '0;
    end else begin
      case (r_state)
        ST_PLL_RESET: begin
          if (r_cnt == c_rst_last) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_timeout_last) begin
            if (r_retries == c_max_retries) begin
              w_state_nxt = ST_FAIL;
            end else begin
              w_retries_nxt = r_retries + c_ret_one;
              w_state_nxt   = ST_PLL_RESET;
              w_cnt_nxt     = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_stable_last) begin
            w_state_nxt   = ST_RUN;
            w_cnt_nxt     = '0;
            w_retries_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            w_state_nxt = ST_PLL_RESET;
            w_cnt_nxt   = '0;
            if (r_loss != 8'hFF) w_loss_nxt = r_loss + 8'd1;
          end
        end
        ST_FAIL: w_state_nxt = ST_FAIL;
        default: begin
          w_state_nxt = ST_PLL_RESET;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they are registered with it
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_state     <= ST_PLL_RESET;
      r_cnt       <= '0;
      r_retries   <= '0;
      r_loss      <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_lock_fail <= 1'b0;
    end else begin
      r_sync1     <= pll_locked;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retries   <= w_retries_nxt;
      r_loss      <= w_loss_nxt;
      r_pll_rst   <= (w_state_nxt == ST_PLL_RESET) || (w_state_nxt == ST_FAIL);
      r_sys_rst_n <= (w_state_nxt == ST_RUN);
      r_lock_fail <= (w_state_nxt == ST_FAIL);
    end
  end

  assign pll_rst    = r_pll_rst;
  assign sys_rst_n  = r_sys_rst_n;
  assign lock_fail  = r_lock_fail;
  assign retries    = r_retries;
  assign loss_count = r_loss;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_ctrl
// Purpose  : Randomized scoreboard bench for pll_reset_ctrl against a
//            countdown-based reference model of the supervisor rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 8;
  localparam int RET_W         = $clog2(MAX_RETRIES + 1);

  localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

  logic             refclk = 1'b0;
  logic             rst_n, pll_locked, soft_req;
  logic             pll_rst, sys_rst_n, lock_fail;
  logic [RET_W-1:0] retries;
  logic [7:0]       loss_count;
  logic [2:0]       state;

  always #5 refclk = ~refclk;

  pll_reset_ctrl #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES(MAX_RETRIES), .CNT_W(CNT_W)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_req(soft_req),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .lock_fail(lock_fail),
    .retries(retries), .loss_count(loss_count), .state(state)
  );

  typedef struct packed {
    logic             pll_rst;
    logic             sys_rst_n;
    logic             lock_fail;
    logic [RET_W-1:0] retries;
    logic [7:0]       loss;
    logic [2:0]       state;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // reference model: phase plus edges remaining until its deadline
  int m_phase, m_remaining, m_retries, m_loss, m_loss_events;
  bit m_hist[$];

  task automatic model_reset();
    m_phase     = P_RESET;
    m_remaining = RST_CYCLES;
    m_retries   = 0;
    m_loss      = 0;
    m_hist      = '{1'b0, 1'b0};
  endtask

  task automatic model_edge(input bit lk, input bit sq);
    bit ls;
    ls = m_hist.pop_front();
    m_hist.push_back(lk);
    if (sq) begin
      m_phase = P_RESET; m_remaining = RST_CYCLES; m_retries = 0;
      return;
    end
    case (m_phase)
      P_RESET: begin
        m_remaining--;
        if (m_remaining == 0) begin m_phase = P_WAIT; m_remaining = LOCK_TIMEOUT; end
      end
      P_WAIT: begin
        if (ls) begin
          m_phase = P_STABLE; m_remaining = STABLE_CYCLES;
        end else begin
          m_remaining--;
          if (m_remaining == 0) begin
            if (m_retries == MAX_RETRIES) m_phase = P_FAIL;
            else begin m_retries++; m_phase = P_RESET; m_remaining = RST_CYCLES; end
          end
        end
      end
      P_STABLE: begin
        if (!ls) begin
          m_phase = P_WAIT; m_remaining = LOCK_TIMEOUT;
        end else begin
          m_remaining--;
          if (m_remaining == 0) begin m_phase = P_RUN; m_retries = 0; end
        end
      end
      P_RUN: begin
        if (!ls) begin
          m_phase = P_RESET; m_remaining = RST_CYCLES;
          m_loss_events++;
          if (m_loss < 255) m_loss++;
        end
      end
      default: ;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pll_rst   = (m_phase == P_RESET) || (m_phase == P_FAIL);
    e.sys_rst_n = (m_phase == P_RUN);
    e.lock_fail = (m_phase == P_FAIL);
    e.retries   = RET_W'(m_retries);
    e.loss      = 8'(m_loss);
    e.state     = 3'(m_phase);
    return e;
  endfunction

  // one refclk period: model consumes the inputs seen at the edge, then new
  // inputs are applied 1 time unit later (an rst_n drop resets at once)
  task automatic cycle(input bit r, input bit lk, input bit sq);
    @(posedge refclk);
    cyc++;
    if (rst_n) model_edge(pll_locked, soft_req);
    #1;
    rst_n = r; pll_locked = lk; soft_req = sq;
    if (!r) model_reset();
    exp_q.push_back(model_out());
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge refclk);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard_underrun: actual=0 entries required=1 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pll_rst",    {7'd0, pll_rst},   {7'd0, e.pll_rst});
        chk("sys_rst_n",  {7'd0, sys_rst_n}, {7'd0, e.sys_rst_n});
        chk("lock_fail",  {7'd0, lock_fail}, {7'd0, e.lock_fail});
        chk("retries",    8'(retries),       8'(e.retries));
        chk("loss_count", loss_count,        e.loss);
        chk("state",      {5'd0, state},     {5'd0, e.state});
      end
    end
  end

  initial begin : stimulus
    int seg_left, rst_left, guard;
    bit seg_lvl, sq, rr;
    rst_n = 1'b0; pll_locked = 1'b0; soft_req = 1'b0;
    m_loss_events = 0;
    model_reset();
    repeat (3) cycle(0, 0, 0);

    // release reset, lock arrives 10 cycles later
    repeat (10) cycle(1, 0, 0);
    repeat (30) cycle(1, 1, 0);

    // frequent short lock drops until loss_count saturates and 3 more losses occur
    guard = 0;
    while (m_loss_events < 258 && guard < 40000) begin
      cycle(1, ($urandom_range(0, 19) != 0), 0);
      guard++;
    end

    // no lock: timeouts into FAIL, then soft restart and normal lock
    repeat (120) cycle(1, 0, 0);
    cycle(1, 0, 1);
    repeat (40) cycle(1, 1, 0);

    // asynchronous reset while in STABLE, then while in RUN
    guard = 0;
    while (m_phase != P_STABLE && guard < 100) begin cycle(1, 1, 0); guard++; end
    cycle(0, 1, 0);
    cycle(1, 1, 0);
    guard = 0;
    while (m_phase != P_RUN && guard < 100) begin cycle(1, 1, 0); guard++; end
    cycle(1, 1, 0);
    cycle(0, 1, 0);

    // long segments, mostly unlocked, occasional soft requests
    seg_left = 0; seg_lvl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (seg_left == 0) begin
        seg_lvl  = ($urandom_range(0, 9) < 3);
        seg_left = $urandom_range(1, 120);
      end
      seg_left--;
      sq = ($urandom_range(0, 99) == 0);
      cycle(1, seg_lvl, sq);
    end

    // mixed short segments with random async resets
    seg_left = 0; rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg_left == 0) begin
        seg_lvl  = $urandom_range(0, 1) == 1;
        seg_left = $urandom_range(1, 30);
      end
      seg_left--;
      if (rst_left == 0 && $urandom_range(0, 149) == 0) rst_left = $urandom_range(1, 3);
      rr = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      sq = ($urandom_range(0, 39) == 0);
      cycle(rr, seg_lvl, sq);
    end

    @(negedge refclk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
